// File: rtl/sa_result_writer_pkg.sv
// -----------------------------------------------------------------------------
// sa_result_writer_pkg
// Shared definitions for the systolic-array result writer:
//   - state_t      : run-control FSM encoding (IDLE / RUN / DONE)
//   - SAT_W        : width of the internal signed working value used for the
//                    shift-and-saturate step (wide enough for any accumulator
//                    width up to 64 bits)
//   - SHIFT_W      : width of the requantization shift amount
//   - DEF_*        : default lane slice widths
//   - sat_signed() : clamps a signed value to a signed out_w-bit range
// -----------------------------------------------------------------------------
package sa_result_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SAT_W         = 64;
    localparam int SHIFT_W       = 5;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_OUT_WIDTH = 8;

    // Clamp v into [-2^(out_w-1), 2^(out_w-1)-1]. The caller keeps the low
    // out_w bits of the result, which are then an exact two's-complement value.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((64'd1 << (out_w - 1)) - 64'd1);
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/sa_result_writer_skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Fixed-length shift register used to realign one array column. DEPTH
// registers sit between d and q; DEPTH = 0 is a plain wire. The line shifts
// every cycle regardless of what the rest of the writer is doing.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears every stage
//   d    : column input (valid bit + data)
//   q    : column output, delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            // The last column needs no delay; clk/rst are intentionally unused.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    // NOTE: this array is a pipeline, not storage, so every
                    // stage is reset; stale valid bits would otherwise leak
                    // phantom rows out of the line after a reset.
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_result_writer.sv
// -----------------------------------------------------------------------------
// sa_result_writer
// Write-back end of the GEMM datapath. Takes the diagonally skewed column
// outputs of a PE_SIZE x PE_SIZE systolic array, realigns them into whole
// rows, requantizes every lane (arithmetic shift + saturation to OUT_WIDTH)
// and writes one packed row per cycle into the output memory (mem2).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : start pulse, honoured only in IDLE
//   base_addr_i     : first write address (latched at start)
//   out_rows_i      : number of rows to write, 0 means 1 (latched at start)
//   shift_i         : requant right-shift amount (latched at start)
//   psum_i          : column j accumulator at [j*ACC_WIDTH +: ACC_WIDTH]
//   psum_valid_i    : per-column valid
//   mem2_ce0/we0    : write strobe (we0 always equals ce0)
//   mem2_addr0/d0   : write address / packed row (lane j at [j*OUT_WIDTH +:])
//   busy_o          : high while a run is in progress
//   done_o          : one-cycle pulse after the last row of a run is written
//   skew_err_o      : sticky, a misaligned row was dropped (cleared on start)
//   ovf_o           : sticky, a valid row came after the run's quota
//                     (cleared on start)
// Latency: column-0 valid at cycle t gives its write strobe at t+PE_SIZE.
// -----------------------------------------------------------------------------
module sa_result_writer
    import sa_result_writer_pkg::*;
#(
    parameter int PE_SIZE         = 16,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH       = DEF_OUT_WIDTH,
    parameter int MEM2_DEPTH      = 896,
    parameter int MEM2_ADDR_WIDTH = 10,
    parameter int MEM2_DATA_WIDTH = PE_SIZE * OUT_WIDTH,
    parameter int ROW_CNT_WIDTH   = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [MEM2_ADDR_WIDTH-1:0]    base_addr_i,
    input  logic [ROW_CNT_WIDTH-1:0]      out_rows_i,
    input  logic [SHIFT_W-1:0]            shift_i,
    input  logic [PE_SIZE*ACC_WIDTH-1:0]  psum_i,
    input  logic [PE_SIZE-1:0]            psum_valid_i,
    output logic                          mem2_ce0,
    output logic                          mem2_we0,
    output logic [MEM2_ADDR_WIDTH-1:0]    mem2_addr0,
    output logic [MEM2_DATA_WIDTH-1:0]    mem2_d0,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          skew_err_o,
    output logic                          ovf_o
);

    // ---------------------------------------------------------------------
    // Deskew: column j is delayed PE_SIZE-1-j cycles so that all lanes of a
    // row line up on the same cycle.
    // ---------------------------------------------------------------------
    logic        [ACC_WIDTH:0]   col_q    [PE_SIZE];
    logic signed [ACC_WIDTH-1:0] col_data [PE_SIZE];
    logic        [PE_SIZE-1:0]   col_valid;

    generate
        for (genvar j = 0; j < PE_SIZE; j++) begin : g_col
            skew_delay_line #(
                .DEPTH (PE_SIZE - 1 - j),
                .WIDTH (ACC_WIDTH + 1)
            ) u_delay (
                .clk (clk),
                .rst (rst),
                .d   ({psum_valid_i[j], psum_i[j*ACC_WIDTH +: ACC_WIDTH]}),
                .q   (col_q[j])
            );
            assign col_valid[j] = col_q[j][ACC_WIDTH];
            assign col_data[j]  = col_q[j][ACC_WIDTH-1:0];
        end
    endgenerate

    // A row is usable only if every lane is valid; a partial row means the
    // upstream skew was broken and the row is discarded.
    logic row_valid;
    logic row_mixed;
    assign row_valid = &col_valid;
    assign row_mixed = (|col_valid) & ~row_valid;

    // ---------------------------------------------------------------------
    // Requantization of the aligned row (registered on the write below).
    // ---------------------------------------------------------------------
    logic [SHIFT_W-1:0]         shift_q;
    logic [MEM2_DATA_WIDTH-1:0] row_quant;
    logic signed [SAT_W-1:0]    lane_wide;
    logic signed [SAT_W-1:0]    lane_sat;

    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path can leave it unassigned and infer a latch.
        row_quant = '0;
        lane_wide = '0;
        lane_sat  = '0;
        for (int j = 0; j < PE_SIZE; j++) begin
            lane_wide = SAT_W'(col_data[j]);
            lane_wide = lane_wide >>> shift_q;
            lane_sat  = sat_signed(lane_wide, OUT_WIDTH);
            row_quant[j*OUT_WIDTH +: OUT_WIDTH] = lane_sat[OUT_WIDTH-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Run control, counters and registered memory interface.
    // ---------------------------------------------------------------------
    state_t                     state;
    logic [MEM2_ADDR_WIDTH-1:0] addr_cnt;
    logic [ROW_CNT_WIDTH-1:0]   rows_written;
    logic [ROW_CNT_WIDTH-1:0]   row_target;
    logic                       quota_met;

    assign quota_met = (rows_written == row_target);
    assign mem2_we0  = mem2_ce0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr_cnt     <= '0;
            rows_written <= '0;
            row_target   <= '0;
            shift_q      <= '0;
            mem2_ce0     <= 1'b0;
            mem2_addr0   <= '0;
            mem2_d0      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            skew_err_o   <= 1'b0;
            ovf_o        <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values regardless of order here.
            mem2_ce0 <= 1'b0;
            done_o   <= 1'b0;

            if (row_mixed) begin
                skew_err_o <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state        <= ST_RUN;
                        busy_o       <= 1'b1;
                        addr_cnt     <= base_addr_i;
                        rows_written <= '0;
                        row_target   <= (out_rows_i == '0) ? ROW_CNT_WIDTH'(1)
                                                           : out_rows_i;
                        shift_q      <= shift_i;
                        skew_err_o   <= row_mixed;
                        ovf_o        <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (quota_met) begin
                        // The last write went out last cycle; finish now.
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        if (row_valid) begin
                            ovf_o <= 1'b1;
                        end
                    end else if (row_valid) begin
                        mem2_ce0     <= 1'b1;
                        mem2_addr0   <= addr_cnt;
                        mem2_d0      <= row_quant;
                        rows_written <= rows_written + ROW_CNT_WIDTH'(1);
                        addr_cnt     <= (addr_cnt == MEM2_ADDR_WIDTH'(MEM2_DEPTH - 1))
                                        ? '0 : addr_cnt + MEM2_ADDR_WIDTH'(1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    if (row_valid) begin
                        ovf_o <= 1'b1;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_result_writer.sv
// -----------------------------------------------------------------------------
// tb_sa_result_writer
// Scoreboard bench for sa_result_writer (PE_SIZE 4, 8-word output memory).
// Each job builds a list of rows, derives the expected memory writes and
// sticky flags from the row-level rules, queues the writes, then streams the
// rows into the DUT with the diagonal skew. A monitor pops and compares every
// write strobe it sees and checks done_o timing.
// -----------------------------------------------------------------------------
module tb_sa_result_writer;

    localparam int PE    = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = PE * OUT_W;
    localparam int RCW   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [AW-1:0]     base_addr_i;
    logic [RCW-1:0]    out_rows_i;
    logic [4:0]        shift_i;
    logic [PE*ACC_W-1:0] psum_i;
    logic [PE-1:0]     psum_valid_i;
    logic              mem2_ce0;
    logic              mem2_we0;
    logic [AW-1:0]     mem2_addr0;
    logic [DW-1:0]     mem2_d0;
    logic              busy_o;
    logic              done_o;
    logic              skew_err_o;
    logic              ovf_o;

    sa_result_writer #(
        .PE_SIZE         (PE),
        .ACC_WIDTH       (ACC_W),
        .OUT_WIDTH       (OUT_W),
        .MEM2_DEPTH      (DEPTH),
        .MEM2_ADDR_WIDTH (AW),
        .MEM2_DATA_WIDTH (DW),
        .ROW_CNT_WIDTH   (RCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .base_addr_i  (base_addr_i),
        .out_rows_i   (out_rows_i),
        .shift_i      (shift_i),
        .psum_i       (psum_i),
        .psum_valid_i (psum_valid_i),
        .mem2_ce0     (mem2_ce0),
        .mem2_we0     (mem2_we0),
        .mem2_addr0   (mem2_addr0),
        .mem2_d0      (mem2_d0),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .skew_err_o   (skew_err_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int job_t0         = 0;
    bit first_pending  = 1'b0;
    int last_write_cyc = -10;
    bit done_expected  = 1'b1;
    int done_cnt       = 0;

    int rd [16][PE];
    bit vm [16][PE];
    int sat_tbl [2][PE] = '{'{300, -300, 255, -1}, '{-1, -16, -17, 1000000}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference requantization: shift, then clamp to the signed OUT_W range.
    function automatic logic [OUT_W-1:0] ref_lane(input int psum, input int sh);
        longint v;
        longint hi;
        longint lo;
        logic [63:0] bits;
        hi   = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo   = -hi - 1;
        v    = longint'(psum) >>> sh;
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
        bits = v;
        return bits[OUT_W-1:0];
    endfunction

    // Monitor: every write strobe is compared against the head of the queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem2_ce0 === 1'b1) begin
                last_write_cyc = cyc;
                check("we0_follows_ce0", mem2_we0, 1);
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", mem2_addr0, e.addr);
                    check("write_data", mem2_d0, e.data);
                end
                if (first_pending) begin
                    check("first_write_latency", cyc - job_t0, PE);
                    first_pending = 1'b0;
                end
            end
            if (done_o === 1'b1) begin
                check("done_allowed", done_expected, 1);
                check("done_after_last_write", cyc, last_write_cyc + 1);
                check("busy_low_at_done", busy_o, 0);
                done_cnt++;
            end
        end
    end

    task automatic run_job(input int base, input int rows, input int sh, input int feed,
                           input int skew_row, input int mode, input bit reset_mid);
        int  cnt_eff;
        int  k;
        int  r;
        int  done_snap;
        int  wait_cyc;
        int  last_c;
        bit  exp_skew;
        bit  exp_ovf;
        bit  all_v;
        bit  any_v;
        wr_t e;

        cnt_eff = (rows == 0) ? 1 : rows;
        for (int rr = 0; rr < feed; rr++) begin
            for (int j = 0; j < PE; j++) begin
                if (mode == 0)      rd[rr][j] = 10 * rr + j;
                else if (mode == 1) rd[rr][j] = sat_tbl[rr % 2][j];
                else if ($urandom_range(0, 1) == 1) rd[rr][j] = int'($urandom);
                else                rd[rr][j] = int'($urandom_range(0, 600)) - 300;
                vm[rr][j] = !(rr == skew_row && j == 2);
            end
        end

        // Row-level model: complete rows fill the quota in order, partial
        // rows are dropped with an error, complete rows past the quota overflow.
        k = 0;
        exp_skew = 1'b0;
        exp_ovf  = 1'b0;
        for (int rr = 0; rr < feed; rr++) begin
            all_v = 1'b1;
            any_v = 1'b0;
            for (int j = 0; j < PE; j++) begin
                all_v &= vm[rr][j];
                any_v |= vm[rr][j];
            end
            if (any_v && !all_v) begin
                exp_skew = 1'b1;
            end else if (all_v) begin
                if (k < cnt_eff) begin
                    if (!reset_mid || k == 0) begin
                        e.addr = AW'((base + k) % DEPTH);
                        e.data = '0;
                        for (int j = 0; j < PE; j++) e.data[j*OUT_W +: OUT_W] = ref_lane(rd[rr][j], sh);
                        exp_q.push_back(e);
                    end
                    k++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        if (reset_mid) begin
            exp_skew = 1'b0;
            exp_ovf  = 1'b0;
        end

        done_snap     = done_cnt;
        done_expected = !reset_mid;
        last_c        = reset_mid ? PE : feed + PE - 2;

        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                job_t0        = cyc;
                first_pending = 1'b1;
            end
            // A second en pulse mid-run with junk settings must be ignored.
            en          = (c == 0) || (c == 2);
            base_addr_i = (c == 0) ? AW'(base) : AW'($urandom);
            out_rows_i  = (c == 0) ? RCW'(rows) : RCW'($urandom_range(1, 9));
            shift_i     = (c == 0) ? 5'(sh) : 5'($urandom);
            rst         = reset_mid && (c == PE);
            for (int j = 0; j < PE; j++) begin
                r = c - j;
                if (r >= 0 && r < feed && !(reset_mid && c == PE)) begin
                    psum_i[j*ACC_W +: ACC_W] = rd[r][j];
                    psum_valid_i[j]          = vm[r][j];
                end else begin
                    psum_i[j*ACC_W +: ACC_W] = $urandom;
                    psum_valid_i[j]          = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        en           = 1'b0;
        rst          = 1'b0;
        psum_valid_i = '0;

        if (reset_mid) begin
            @(negedge clk);
            check("strobe_low_after_reset", mem2_ce0, 0);
            check("busy_low_after_reset", busy_o, 0);
            repeat (6) @(posedge clk);
            @(negedge clk);
        end else begin
            wait_cyc = 0;
            while (done_cnt == done_snap && wait_cyc < 100) begin
                @(posedge clk);
                wait_cyc++;
            end
            check("done_seen", done_cnt != done_snap, 1);
            repeat (4) @(posedge clk);
            @(negedge clk);
        end
        check("skew_err_flag", skew_err_o, exp_skew);
        check("ovf_flag", ovf_o, exp_ovf);
        check("busy_idle", busy_o, 0);
        check("all_writes_seen", exp_q.size(), 0);
        exp_q.delete();
        first_pending = 1'b0;
        done_expected = 1'b1;
    endtask

    initial begin
        int extras;
        int rows;
        rst          = 1'b1;
        en           = 1'b0;
        base_addr_i  = '0;
        out_rows_i   = '0;
        shift_i      = '0;
        psum_i       = '0;
        psum_valid_i = '0;
        done_expected = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ce0", mem2_ce0, 0);
        check("reset_we0", mem2_we0, 0);
        check("reset_addr", mem2_addr0, 0);
        check("reset_data", mem2_d0, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_skew_err", skew_err_o, 0);
        check("reset_ovf", ovf_o, 0);
        rst = 1'b0;
        done_expected = 1'b1;
        repeat (2) @(posedge clk);

        run_job(5, 3, 0, 3, -1, 0, 1'b0);   // basic: addr 5,6,7, lanes 10r+j
        run_job(0, 2, 1, 2, -1, 1, 1'b0);   // saturation, shift 1
        run_job(3, 2, 4, 2, -1, 1, 1'b0);   // saturation, shift 4
        run_job(6, 4, 0, 4, -1, 2, 1'b0);   // wrap 6,7,0,1
        run_job(0, 2, 0, 3, 1, 2, 1'b0);    // row 1 misaligned on column 2
        run_job(2, 2, 0, 3, -1, 2, 1'b0);   // one row too many
        run_job(4, 0, 0, 1, -1, 2, 1'b0);   // zero row count acts as one
        run_job(1, 3, 0, 3, -1, 0, 1'b1);   // reset after the first write
        run_job(5, 3, 0, 3, -1, 0, 1'b0);   // clean run after reset

        for (int n = 0; n < 20; n++) begin
            rows   = $urandom_range(1, 6);
            extras = $urandom_range(0, 2);
            run_job($urandom_range(0, DEPTH - 1), rows, $urandom_range(0, 31),
                    rows + extras, -1, 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/sa_result_writer.md
# sa_result_writer

Write-back end of the GEMM datapath: the counterpart to the weight/feature data mover and GLB read path. Accepts the skewed per-column accumulator outputs of the PE_SIZE×PE_SIZE systolic array, deskews them into whole rows, requantizes each lane to OUT_WIDTH, and writes one packed row per cycle into the output BRAM (mem2) through a single-port ce/we/addr/d interface. A run is armed by `en`; `done_o` pulses after the programmed row count is written.

## Interface
- PE_SIZE, 16, array columns = lanes per row
- ACC_WIDTH, 32, signed accumulator width per lane
- OUT_WIDTH, 8, signed output width per lane
- MEM2_DEPTH, 896, output memory words
- MEM2_ADDR_WIDTH, 10, output memory address width
- MEM2_DATA_WIDTH, 128, = PE_SIZE*OUT_WIDTH
- ROW_CNT_WIDTH, 10, width of row-count input

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  MEM2_ADDR_WIDTH  first write address, latched on start
- out_rows_i  in  ROW_CNT_WIDTH  rows to write (0 treated as 1), latched on start
- shift_i  in  5  arithmetic right shift before saturation, latched on start
- psum_i  in  PE_SIZE*ACC_WIDTH  column j at bits [j*ACC_WIDTH +: ACC_WIDTH]
- psum_valid_i  in  PE_SIZE  per-column valid
- mem2_ce0  out  1  memory enable
- mem2_we0  out  1  write enable (equal to mem2_ce0)
- mem2_addr0  out  MEM2_ADDR_WIDTH  write address
- mem2_d0  out  MEM2_DATA_WIDTH  packed row, lane j at [j*OUT_WIDTH +: OUT_WIDTH]
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse at run end
- skew_err_o  out  1  sticky: misaligned row seen; cleared on next start
- ovf_o  out  1  sticky: valid row arrived after count exhausted; cleared on next start

## Operation
- FSM: IDLE -> RUN on `en`; RUN -> DONE when row counter reaches latched count after its write; DONE -> IDLE unconditionally (one cycle, `done_o`=1).
- Input contract: row r of column j arrives at cycle t0+r+j (standard diagonal skew).
- Deskew: column j passes through PE_SIZE-1-j registers (data and valid); column PE_SIZE-1 has zero delay. Delay lines shift every cycle in all states.
- Row check: deskewed valids all 1 -> valid row; all 0 -> idle; mixed -> row dropped, `skew_err_o` set.
- Requant per lane: v = psum >>> shift (arithmetic); saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; registered.
- Write: in RUN, each valid row writes `mem2_d0` at current address; address then increments, wrapping MEM2_DEPTH-1 -> 0.
- Valid rows in IDLE/DONE, or after count reached, are not written; in RUN-after-count or DONE they set `ovf_o`.
- `en` while RUN/DONE ignored.
- Reset: FSM IDLE, delay lines and valids cleared, all outputs 0 (addr 0, data 0, flags 0).

## Timing
- Column-0 valid at cycle t -> write strobe (ce0=we0=1) at cycle t+PE_SIZE (PE_SIZE-1 deskew + 1 requant register).
- Back-to-back rows: one write per cycle, no bubbles; memory is always ready.
- Last write at cycle w -> `done_o`=1 and busy_o=0 at w+1; IDLE at w+2; new `en` accepted at w+2.
- `en` and first valid may coincide; rows whose write cycle falls before RUN is entered are dropped (no ovf).
- rst asserted mid-run: next cycle all strobes low, in-flight rows discarded, no `done_o`.

## Structure
- Shared package: state encoding (IDLE/RUN/DONE), saturation helper function, lane slice width constants.
- One sub-module `skew_delay_line` (parameter DEPTH, WIDTH; DEPTH=0 passthrough), instantiated per column via generate.
- Top holds FSM, row/address counters, row check, requant and output registers.

## Test plan
- PE_SIZE=4, base 5, rows 3, shift 0, column j row r value 10r+j, correct skew -> writes at addr 5,6,7 with lanes {0,1,2,3},{10,11,12,13},{20,21,22,23}; first write 4 cycles after first col-0 valid; `done_o` one cycle after addr 7.
- Saturation: psum 300, -300, 255 with shift 1, OUT_WIDTH 8 -> 127, -128, 127; psum -1 shift 4 -> -1.
- Wrap: MEM2_DEPTH 8, base 6, rows 4 -> addresses 6,7,0,1.
- Skew fault: column 2 valid one cycle late for row 1 -> row 1 not written, `skew_err_o`=1 until next `en`, other rows written.
- Overflow: rows 2, feed 3 valid rows -> 2 writes, `ovf_o`=1, no third strobe.
- Reset mid-run after 1 of 3 rows -> strobes low next cycle, busy_o=0, no `done_o`; new run from base writes correctly.
